// File: rtl/led_sched_pkg.sv
// Shared types for the LED scheduler: LED word width and FSM state encoding.
package led_sched_pkg;

    localparam int unsigned LED_W = 8;

    typedef logic [LED_W-1:0] led_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_e;

endpackage : led_sched_pkg

// File: rtl/led_scheduler_if.sv
// Bus between the pattern requesters and the LED scheduler.
//   req_i   : per-requester level request (requester -> scheduler)
//   pat_i   : per-requester 8-bit pattern, packed [N_REQ-1:0][7:0]
//   grant_o : one-hot current owner, zero when idle
//   busy_o  : high while an owner holds the LEDs
//   tick_o  : one-cycle dwell time-base pulse
//   led_o   : registered LED drive
interface led_scheduler_if
    import led_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 4
);

    logic [N_REQ-1:0]            req_i;
    logic [N_REQ-1:0][LED_W-1:0] pat_i;
    logic [N_REQ-1:0]            grant_o;
    logic                        busy_o;
    logic                        tick_o;
    led_t                        led_o;

    // Requester side (or a testbench) drives requests and patterns.
    modport master (
        output req_i,
        output pat_i,
        input  grant_o,
        input  busy_o,
        input  tick_o,
        input  led_o
    );

    // Scheduler side.
    modport slave (
        input  req_i,
        input  pat_i,
        output grant_o,
        output busy_o,
        output tick_o,
        output led_o
    );

endinterface : led_scheduler_if

// File: rtl/tick_gen.sv
// Free-running prescaler producing the dwell time base.
//   clk_i  : system clock
//   rst_i  : synchronous active-high reset
//   tick_o : registered one-cycle pulse, high while the count sits at TICK_DIV-1
module tick_gen #(
    parameter int unsigned TICK_DIV = 12_500_000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_d;

    // Next count wraps at TICK_DIV-1; tick is decoded from the next count so
    // the registered pulse lines up with the cycle where the count is TICK_DIV-1.
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
            cnt_d = '0;
        end
        tick_d = (cnt_d == CNT_W'(TICK_DIV - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tick_o <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_o <= tick_d;
        end
    end

endmodule : tick_gen

// File: rtl/led_scheduler.sv
// Round-robin time-multiplexer of the 8-LED bank between N_REQ requesters,
// with a tick-based dwell limit per grant.
//   clk_i : system clock
//   rst_i : synchronous active-high reset
//   bus   : slave side of led_scheduler_if (req_i, pat_i in; grant_o,
//           busy_o, tick_o, led_o out, all outputs registered)
module led_scheduler
    import led_sched_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned TICK_DIV = 12_500_000,
    parameter int unsigned DWELL    = 4,
    parameter led_t        IDLE_PAT = 8'h00
) (
    input  logic            clk_i,
    input  logic            rst_i,
    led_scheduler_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned DW_W  = $clog2(DWELL + 1);

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [N_REQ-1:0] vec_t;

    // First set bit of req, searching last+1, last+2, ... modulo N_REQ.
    function automatic idx_t rr_pick(input vec_t req, input idx_t last);
        idx_t pick;
        idx_t idx;
        logic found;
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = IDX_W'((32'(last) + i) % N_REQ);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    logic tick;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick_o (tick)
    );

    assign bus.tick_o = tick;

    state_e          state_q, state_d;
    idx_t            owner_q, owner_d;
    idx_t            ptr_q,   ptr_d;
    logic [DW_W-1:0] dwell_q, dwell_d;
    vec_t            grant_q, grant_d;
    led_t            led_q,   led_d;
    logic            busy_q,  busy_d;

    vec_t            others;
    idx_t            pick_idle;
    idx_t            pick_own;
    logic            expiry;

    // Requests other than the current owner; the owner is never re-picked on expiry.
    assign others    = bus.req_i & ~(N_REQ'(1) << owner_q);
    assign pick_idle = rr_pick(bus.req_i, ptr_q);
    assign pick_own  = rr_pick(others, ptr_q);
    assign expiry    = tick && (dwell_q == DW_W'(1));

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        dwell_d = dwell_q;
        grant_d = '0;
        led_d   = IDLE_PAT;
        busy_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|bus.req_i) begin
                    state_d = S_OWN;
                    owner_d = pick_idle;
                    ptr_d   = pick_idle;
                    dwell_d = DW_W'(DWELL);
                end
            end

            S_OWN: begin
                if (tick) begin
                    dwell_d = dwell_q - DW_W'(1);
                end
                // Release has priority, so release+expiry behaves as a release.
                if (!bus.req_i[owner_q]) begin
                    if (|others) begin
                        owner_d = pick_own;
                        ptr_d   = pick_own;
                        dwell_d = DW_W'(DWELL);
                    end else begin
                        state_d = S_IDLE;
                        dwell_d = '0;
                    end
                end else if (expiry) begin
                    if (|others) begin
                        owner_d = pick_own;
                        ptr_d   = pick_own;
                    end
                    dwell_d = DW_W'(DWELL);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Grant and LED drive both derive from the next owner so they never disagree.
        if (state_d == S_OWN) begin
            grant_d = N_REQ'(1) << owner_d;
            led_d   = bus.pat_i[owner_d];
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            ptr_q   <= IDX_W'(N_REQ - 1);
            dwell_q <= '0;
            grant_q <= '0;
            led_q   <= IDLE_PAT;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            dwell_q <= dwell_d;
            grant_q <= grant_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.grant_o = grant_q;
    assign bus.led_o   = led_q;
    assign bus.busy_o  = busy_q;

endmodule : led_scheduler

// File: tb/tb_led_scheduler.sv
// Directed testbench for led_scheduler with TICK_DIV=4, DWELL=2, N_REQ=4.
module tb_led_scheduler;
    import led_sched_pkg::*;

    localparam int unsigned N_REQ    = 4;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned DWELL    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_pass  = 0;
    int n_total = 0;

    led_scheduler_if #(.N_REQ(N_REQ)) bus ();

    led_scheduler #(
        .N_REQ    (N_REQ),
        .TICK_DIV (TICK_DIV),
        .DWELL    (DWELL),
        .IDLE_PAT (8'h00)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Count cycles of the current grant (current cycle included) until it changes.
    // pt is tick_o in the last cycle before the change; len=-1 on timeout.
    task automatic measure(output logic [3:0] g, output int len, output logic pt);
        logic [3:0] cur;
        logic       done;
        cur  = bus.grant_o;
        g    = cur;
        len  = 1;
        pt   = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!done) begin
                pt = bus.tick_o;
                step();
                if (bus.grant_o !== cur) begin
                    g    = bus.grant_o;
                    done = 1'b1;
                end else begin
                    len++;
                end
            end
        end
        if (!done) len = -1;
    endtask

    initial begin
        logic [3:0] g;
        int         len;
        logic       pt;
        logic       held;
        logic [3:0] rot_g [4];
        led_t       rot_led [4];
        int         rot_len [4];

        rot_g   = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rot_led = '{8'h02, 8'h04, 8'h08, 8'h01};
        rot_len = '{7, 8, 8, 8};

        bus.req_i = '0;
        bus.pat_i = {8'h08, 8'h04, 8'h02, 8'h01};

        // Power-on reset
        rst = 1'b1;
        step_n(2);
        rst = 1'b0;
        check("por_grant", 32'(bus.grant_o), 32'h0);
        check("por_led",   32'(bus.led_o),   32'h00);
        check("por_tick",  32'(bus.tick_o),  32'h0);
        check("por_busy",  32'(bus.busy_o),  32'h0);

        // Owner 2, then reset mid-ownership
        bus.req_i = 4'b0100;
        step();
        check("own2_grant", 32'(bus.grant_o), 32'b0100);
        check("own2_led",   32'(bus.led_o),   32'h04);
        check("own2_busy",  32'(bus.busy_o),  32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_grant", 32'(bus.grant_o), 32'h0);
        check("mrst_led",   32'(bus.led_o),   32'h00);
        check("mrst_tick",  32'(bus.tick_o),  32'h0);
        check("mrst_busy",  32'(bus.busy_o),  32'h0);
        bus.req_i = 4'b1111;
        step();
        check("first_grant", 32'(bus.grant_o), 32'b0001);
        check("first_led",   32'(bus.led_o),   32'h01);
        bus.req_i = 4'b0000;
        step();
        check("rel_idle_grant", 32'(bus.grant_o), 32'h0);
        check("rel_idle_led",   32'(bus.led_o),   32'h00);

        // Single requester holds through expiries
        bus.pat_i[0] = 8'hA5;
        bus.req_i    = 4'b0001;
        step();
        check("single_grant", 32'(bus.grant_o), 32'b0001);
        check("single_led",   32'(bus.led_o),   32'hA5);
        held = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.grant_o !== 4'b0001 || bus.led_o !== 8'hA5) held = 1'b0;
        end
        check("single_hold", 32'(held), 32'h1);
        bus.pat_i[0] = 8'h3C;
        step();
        check("pat_change_led", 32'(bus.led_o), 32'h3C);
        bus.pat_i[0] = 8'h01;

        // Full rotation from a known prescaler phase
        bus.req_i = 4'b0000;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req_i = 4'b1111;
        step();
        check("rot_start", 32'(bus.grant_o), 32'b0001);
        for (int k = 0; k < 4; k++) begin
            measure(g, len, pt);
            check("rot_grant", 32'(g), 32'(rot_g[k]));
            check("rot_len",   32'(len), 32'(rot_len[k]));
            check("rot_tick",  32'(pt), 32'h1);
            check("rot_led",   32'(bus.led_o), 32'(rot_led[k]));
        end

        // Early release with another request pending, then to idle
        measure(g, len, pt);
        check("er_own1", 32'(g), 32'b0010);
        step_n(2);
        bus.req_i = 4'b1000;
        step();
        check("er_grant", 32'(bus.grant_o), 32'b1000);
        check("er_led",   32'(bus.led_o),   32'h08);
        bus.req_i = 4'b0010;
        step();
        check("er_back1", 32'(bus.grant_o), 32'b0010);
        bus.req_i = 4'b0000;
        step();
        check("er_idle_grant", 32'(bus.grant_o), 32'h0);
        check("er_idle_led",   32'(bus.led_o),   32'h00);
        check("er_idle_busy",  32'(bus.busy_o),  32'h0);

        // Release exactly on the expiry tick
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req_i = 4'b0100;
        step();
        check("sim_own2", 32'(bus.grant_o), 32'b0100);
        step_n(6);
        check("sim_tick",  32'(bus.tick_o),  32'h1);
        check("sim_pre",   32'(bus.grant_o), 32'b0100);
        bus.req_i = 4'b0001;
        step();
        check("sim_grant", 32'(bus.grant_o), 32'b0001);
        check("sim_led",   32'(bus.led_o),   32'h01);
        check("sim_busy",  32'(bus.busy_o),  32'h1);

        // Pointer wrap-around 3 -> 0 -> 3
        bus.req_i = 4'b1000;
        step();
        check("wrap_own3", 32'(bus.grant_o), 32'b1000);
        bus.req_i = 4'b1001;
        measure(g, len, pt);
        check("wrap_to0",     32'(g),   32'b0001);
        check("wrap_to0_len", 32'(len), 32'd7);
        check("wrap_to0_tick", 32'(pt), 32'h1);
        measure(g, len, pt);
        check("wrap_to3",     32'(g),   32'b1000);
        check("wrap_to3_len", 32'(len), 32'd8);
        check("wrap_to3_led", 32'(bus.led_o), 32'h08);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_led_scheduler
